// File: rtl/sm_clk_ctrl_pkg.sv
// rtl/sm_clk_ctrl_pkg.sv - shared state encoding and rate helper for the run/step/halt controller
package sm_clk_ctrl_pkg;

   typedef enum logic {
      SM_CLK_HALT = 1'b0,
      SM_CLK_RUN  = 1'b1
   } sm_clk_state_t;

   // Terminal count for a run-mode tick period of 2^exp clocks.
   function automatic logic [31:0] calc_limit(input logic [4:0] exp);
      return (32'd1 << exp) - 32'd1;
   endfunction

endpackage

// File: rtl/sm_edge_rise.sv
// rtl/sm_edge_rise.sv - SIZE-wide rising-edge detector with async active-low reset
module sm_edge_rise #(
   parameter int SIZE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] d,
   output logic [SIZE-1:0] rise
);

   logic [SIZE-1:0] prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= '0;
      end else begin
         prev <= d;
      end
   end

   assign rise = d & ~prev;

endmodule

// File: rtl/sm_clk_ctrl.sv
// rtl/sm_clk_ctrl.sv - run/step/halt controller issuing one-cycle CPU enable pulses
module sm_clk_ctrl
   import sm_clk_ctrl_pkg::*;
#(
   parameter int SHIFT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        step,
   input  logic [3:0]  devide,
   input  logic        breakEn,
   input  logic [31:0] breakAddr,
   input  logic [31:0] pc,
   output logic        cpuEn,
   output logic        halted,
   output logic        brkHit,
   output logic [31:0] instrCnt
);

   logic          run_rise;
   logic          step_rise;
   logic [31:0]   limit;
   logic [31:0]   cntr;
   sm_clk_state_t state;

   sm_edge_rise #(.SIZE(1)) u_run_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (run),
      .rise  (run_rise)
   );

   sm_edge_rise #(.SIZE(1)) u_step_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (step),
      .rise  (step_rise)
   );

   assign limit = calc_limit(5'(SHIFT) + {1'b0, devide});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SM_CLK_HALT;
         cntr     <= '0;
         cpuEn    <= 1'b0;
         halted   <= 1'b1;
         brkHit   <= 1'b0;
         instrCnt <= '0;
      end else begin
         cpuEn <= 1'b0;
         case (state)
            SM_CLK_HALT: begin
               // A run edge takes priority; a simultaneous step edge is dropped.
               if (run_rise) begin
                  state  <= SM_CLK_RUN;
                  halted <= 1'b0;
                  cntr   <= '0;
                  brkHit <= 1'b0;
               end else if (step_rise) begin
                  cpuEn  <= 1'b1;
                  brkHit <= 1'b0;
               end
            end
            SM_CLK_RUN: begin
               if (!run) begin
                  state  <= SM_CLK_HALT;
                  halted <= 1'b1;
               end else if (cntr >= limit) begin
                  // >= so a lowered rate ticks at once instead of wrapping the counter.
                  cntr <= '0;
                  if (breakEn && (pc == breakAddr)) begin
                     state  <= SM_CLK_HALT;
                     halted <= 1'b1;
                     brkHit <= 1'b1;
                  end else begin
                     cpuEn <= 1'b1;
                  end
               end else begin
                  cntr <= cntr + 32'd1;
               end
            end
            default: begin
               state  <= SM_CLK_HALT;
               halted <= 1'b1;
            end
         endcase
         if (cpuEn) begin
            instrCnt <= instrCnt + 32'd1;
         end
      end
   end

endmodule
